// File: rtl/fifo_rd_packer_if.sv
// ============================================================================
// Module      : fifo_rd_packer_if
// Description : FIFO read port plus packed-word stream for fifo_rd_packer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_rd_packer_if #(
    parameter int WORD_BYTES = 2
);
    logic                    empty;
    logic                    rdreq;
    logic [7:0]              fifo_data;
    logic [8*WORD_BYTES-1:0] out_data;
    logic [WORD_BYTES-1:0]   out_keep;
    logic                    out_valid;
    logic                    out_ready;
    logic                    flush;
    logic                    busy;

    modport master (
        input  empty, fifo_data, out_ready, flush,
        output rdreq, out_data, out_keep, out_valid, busy
    );

    modport slave (
        output empty, fifo_data, out_ready, flush,
        input  rdreq, out_data, out_keep, out_valid, busy
    );
endinterface

`default_nettype wire

// File: rtl/fifo_rd_packer.sv
// ============================================================================
// Module      : fifo_rd_packer
// Description : Pops bytes from a FIFO read port and packs them little-endian
//               into keep-masked words on a valid/ready stream, with flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_packer #(
    parameter int WORD_BYTES = 2,
    parameter int CNT_W      = 16
) (
    input  wire logic            rdclk,
    input  wire logic            rst,
    fifo_rd_packer_if.master     bus,
    output logic [CNT_W-1:0]     word_count
);

    localparam int              CW     = $clog2(WORD_BYTES + 1);
    localparam logic [CW-1:0]   C_FULL = CW'(WORD_BYTES);

    typedef enum logic [0:0] {
        S_FILL  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t                  r_state;
    logic [CW-1:0]           r_cnt;
    logic                    r_pend;
    logic [8*WORD_BYTES-1:0] r_acc;
    logic [8*WORD_BYTES-1:0] r_out_data;
    logic [WORD_BYTES-1:0]   r_out_keep;
    logic                    r_out_valid;
    logic [CNT_W-1:0]        r_word_count;

    logic                    w_flushing;
    logic                    w_slot_free;
    logic                    w_load_full;
    logic                    w_load_part;
    logic                    w_load;
    logic                    w_below;
    logic                    w_rdreq;
    logic                    w_accept;
    logic [WORD_BYTES-1:0]   w_mask;
    logic [8*WORD_BYTES-1:0] w_word;

    assign w_flushing  = (r_state == S_DRAIN);
    assign w_slot_free = !r_out_valid || bus.out_ready;
    assign w_load_full = (r_cnt == C_FULL) && w_slot_free;
    // A partial word may only leave once no byte is still in flight.
    assign w_load_part = w_flushing && !r_pend && (r_cnt != '0) &&
                         (r_cnt != C_FULL) && w_slot_free;
    assign w_load      = w_load_full || w_load_part;
    assign w_below     = ({1'b0, r_cnt} + {{CW{1'b0}}, r_pend}) < {1'b0, C_FULL};
    assign w_rdreq     = !rst && !bus.empty && !w_flushing && (w_below || w_load_full);
    assign w_accept    = r_out_valid && bus.out_ready;

    always_comb begin
        w_mask = '1;
        w_word = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (w_load_part) begin
                w_mask[i] = (CW'(i) < r_cnt);
            end
            w_word[8*i +: 8] = w_mask[i] ? r_acc[8*i +: 8] : 8'h00;
        end
    end

    always_ff @(posedge rdclk or posedge rst) begin
        if (rst) begin
            r_state      <= S_FILL;
            r_cnt        <= '0;
            r_pend       <= 1'b0;
            r_acc        <= '0;
            r_out_data   <= '0;
            r_out_keep   <= '0;
            r_out_valid  <= 1'b0;
            r_word_count <= '0;
        end else begin
            r_pend <= w_rdreq;

            // Incoming byte lands in lane 0 when the accumulator empties this cycle.
            if (r_pend) begin
                for (int i = 0; i < WORD_BYTES; i++) begin
                    if (CW'(i) == (w_load ? '0 : r_cnt)) begin
                        r_acc[8*i +: 8] <= bus.fifo_data;
                    end
                end
                r_cnt <= w_load ? CW'(1) : r_cnt + CW'(1);
            end else if (w_load) begin
                r_cnt <= '0;
            end

            if (w_load) begin
                r_out_data  <= w_word;
                r_out_keep  <= w_mask;
                r_out_valid <= 1'b1;
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
            end

            if (w_accept) begin
                r_word_count <= r_word_count + CNT_W'(1);
            end

            case (r_state)
                S_FILL: begin
                    if (bus.flush) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!r_pend && ((r_cnt == '0) || w_load_part)) begin
                        r_state <= S_FILL;
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

    assign bus.rdreq     = w_rdreq;
    assign bus.out_data  = r_out_data;
    assign bus.out_keep  = r_out_keep;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = (r_cnt != '0) || r_pend || r_out_valid || w_flushing;
    assign word_count    = r_word_count;

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_packer.sv
// ============================================================================
// Module      : tb_fifo_rd_packer
// Description : Scoreboard bench for fifo_rd_packer (WORD_BYTES=2, CNT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_rd_packer;

    typedef struct packed {
        logic [1:0]  keep;
        logic [15:0] data;
    } exp_t;

    logic       rdclk = 1'b0;
    logic       rst   = 1'b0;
    logic [3:0] word_count;

    int checks   = 0;
    int failures = 0;

    logic [7:0] fifo_q[$];
    exp_t       exp_q[$];

    logic        stalled = 1'b0;
    logic [15:0] held_data = '0;

    fifo_rd_packer_if #(.WORD_BYTES(2)) bus ();

    fifo_rd_packer #(
        .WORD_BYTES (2),
        .CNT_W      (4)
    ) u_dut (
        .rdclk      (rdclk),
        .rst        (rst),
        .bus        (bus.master),
        .word_count (word_count)
    );

    always #5 rdclk = ~rdclk;

    // FIFO model: data appears one cycle after an accepted pop.
    always @(posedge rdclk) begin
        if (bus.rdreq === 1'b1 && bus.empty === 1'b0) begin
            bus.fifo_data <= fifo_q.pop_front();
        end
        bus.empty <= (fifo_q.size() == 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: scoreboard pops, hold-under-backpressure, rdreq/empty legality.
    always @(negedge rdclk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (bus.rdreq === 1'b1 && bus.empty === 1'b1) begin
                chk("rdreq_while_empty", 32'd1, 32'd0);
            end
            if (stalled) begin
                chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
                chk("hold_data", {16'd0, bus.out_data}, {16'd0, held_data});
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {16'd0, bus.out_data}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("word_data", {16'd0, bus.out_data}, {16'd0, e.data});
                    chk("word_keep", {30'd0, bus.out_keep}, {30'd0, e.keep});
                end
            end
            stalled   = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
            held_data = bus.out_data;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge rdclk);
        #1;
    endtask

    task automatic expect_word(input logic [15:0] d, input logic [1:0] k);
        exp_t e;
        e.data = d;
        e.keep = k;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge rdclk);
            if (exp_q.size() == 0 && fifo_q.size() == 0 && bus.busy === 1'b0) done = 1'b1;
        end
        chk(name, {31'd0, done}, 32'd1);
        tick(1);
    endtask

    task automatic wait_fifo_drained(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge rdclk);
            if (fifo_q.size() == 0) done = 1'b1;
        end
        chk(name, {31'd0, done}, 32'd1);
        tick(3);
    endtask

    task automatic pulse_flush();
        bus.flush = 1'b1;
        tick(1);
        bus.flush = 1'b0;
    endtask

    initial begin
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        #1 rst = 1'b1;
        #5;
        chk("rst_rdreq", {31'd0, bus.rdreq}, 32'd0);
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_data", {16'd0, bus.out_data}, 32'd0);
        chk("rst_keep", {30'd0, bus.out_keep}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_count", {28'd0, word_count}, 32'd0);
        tick(2);
        rst = 1'b0;
        tick(2);

        // Streaming with out_ready held high
        bus.out_ready = 1'b1;
        expect_word(16'h2211, 2'b11);
        expect_word(16'h4433, 2'b11);
        foreach (fifo_q[i]) ;
        fifo_q.push_back(8'h11); fifo_q.push_back(8'h22);
        fifo_q.push_back(8'h33); fifo_q.push_back(8'h44);
        wait_idle("stream_idle");
        chk("stream_count", {28'd0, word_count}, 32'd2);
        chk("stream_busy", {31'd0, bus.busy}, 32'd0);

        // Backpressure: slot and accumulator both fill, popping stops
        bus.out_ready = 1'b0;
        expect_word(16'h0201, 2'b11);
        expect_word(16'h0403, 2'b11);
        expect_word(16'h0605, 2'b11);
        for (int i = 1; i <= 6; i++) fifo_q.push_back(8'(i));
        tick(10);
        chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("bp_data", {16'd0, bus.out_data}, 32'h0201);
        chk("bp_rdreq", {31'd0, bus.rdreq}, 32'd0);
        chk("bp_fifo_left", fifo_q.size(), 32'd2);
        bus.out_ready = 1'b1;
        wait_idle("bp_idle");
        chk("bp_count", {28'd0, word_count}, 32'd5);

        // Partial flush
        expect_word(16'hB2A1, 2'b11);
        expect_word(16'h00C3, 2'b01);
        fifo_q.push_back(8'hA1); fifo_q.push_back(8'hB2); fifo_q.push_back(8'hC3);
        wait_fifo_drained("pf_drain");
        chk("pf_busy_before", {31'd0, bus.busy}, 32'd1);
        pulse_flush();
        wait_idle("pf_idle");
        chk("pf_count", {28'd0, word_count}, 32'd7);

        // Flush coincident with an accepted pop
        expect_word(16'h005A, 2'b01);
        fifo_q.push_back(8'h5A);
        tick(1);
        chk("fp_rdreq", {31'd0, bus.rdreq}, 32'd1);
        pulse_flush();
        wait_idle("fp_idle");
        chk("fp_count", {28'd0, word_count}, 32'd8);
        pulse_flush();
        tick(6);
        chk("empty_flush_count", {28'd0, word_count}, 32'd8);
        chk("empty_flush_busy", {31'd0, bus.busy}, 32'd0);

        // Reset mid-stream with cnt=1 and a word pending
        bus.out_ready = 1'b0;
        fifo_q.push_back(8'h01); fifo_q.push_back(8'h02); fifo_q.push_back(8'h03);
        tick(8);
        chk("mr_valid_before", {31'd0, bus.out_valid}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("mr_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mr_data", {16'd0, bus.out_data}, 32'd0);
        chk("mr_keep", {30'd0, bus.out_keep}, 32'd0);
        chk("mr_busy", {31'd0, bus.busy}, 32'd0);
        chk("mr_count", {28'd0, word_count}, 32'd0);
        exp_q.delete();
        fifo_q.delete();
        fifo_q.push_back(8'h77);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("mr_rdreq_in_reset", {31'd0, bus.rdreq}, 32'd0);
        end
        expect_word(16'h0077, 2'b01);
        bus.out_ready = 1'b1;
        rst = 1'b0;
        wait_fifo_drained("mr_drain");
        pulse_flush();
        wait_idle("mr_idle");
        chk("mr_count_after", {28'd0, word_count}, 32'd1);

        // Counter wrap: 17 words into a 4-bit counter
        #1 rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk("wrap_start", {28'd0, word_count}, 32'd0);
        for (int w = 0; w < 17; w++) begin
            expect_word({8'(2*w+1), 8'(2*w)}, 2'b11);
            fifo_q.push_back(8'(2*w));
            fifo_q.push_back(8'(2*w+1));
        end
        wait_idle("wrap_idle");
        chk("wrap_count", {28'd0, word_count}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Read-side consumer for the dual-clock byte FIFO; runs entirely in the rdclk domain.
- Pops bytes via rdreq/empty and packs WORD_BYTES consecutive bytes little-endian into one word.
- Presents each word on a valid/ready stream with a per-byte keep mask.
- A flush request drains a partially assembled word, so downstream logic gets the FIFO contents as words without handling FIFO read latency.

Parameters:
- WORD_BYTES, 2, bytes per output word (2..8).
- CNT_W, 16, width of the delivered-word counter.

Ports:
- rdclk  input  1  clock (FIFO read clock).
- rst  input  1  reset, asynchronous, active-high.
- empty  input  1  FIFO empty flag, rdclk domain.
- rdreq  output  1  FIFO pop request.
- fifo_data  input  8  FIFO read data, valid one cycle after an accepted pop.
- out_data  output  8*WORD_BYTES  packed word; byte 0 in bits [7:0].
- out_keep  output  WORD_BYTES  byte-valid mask for out_data.
- out_valid  output  1  word available.
- out_ready  input  1  downstream accepts the word.
- flush  input  1  single-cycle pulse: emit any partial word.
- busy  output  1  block holds or awaits data.
- word_count  output  CNT_W  words delivered since reset.

Behaviour:
- Reset (async assert, sampled release) clears all state and outputs:
  - rdreq=0, out_valid=0, out_data=0, out_keep=0.
  - word_count=0, cnt=0, pend=0, flushing=0, busy=0.
- An accepted pop is rdreq=1 with empty=0. rdreq is never asserted while empty=1.
- Pop latency:
  - pend=1 in the cycle after an accepted pop.
  - In that cycle fifo_data is stored to byte lane cnt of the accumulator, and cnt increments.
- Output slot free when out_valid=0 OR out_ready=1.
- load = (cnt==WORD_BYTES) AND slot free.
- On load:
  - out_data <= accumulator, out_keep <= all ones, out_valid <= 1, cnt <= 0.
  - A pend byte arriving in the same cycle is written to lane 0, and cnt <= 1.
- rdreq = !empty AND !flushing AND ((cnt + pend < WORD_BYTES) OR load).
  - This never over-issues, so cnt never exceeds WORD_BYTES.
- Handshake:
  - out_valid&&out_ready with no load the same cycle -> out_valid <= 0.
  - out_data/out_keep hold while out_valid=1 and out_ready=0.
- word_count increments on every out_valid&&out_ready, wraps modulo 2^CNT_W.
- States:
  - FILL (flushing=0).
  - DRAIN (flushing=1), entered on flush=1 from FILL. flush while already in DRAIN is ignored.
- DRAIN behaviour:
  - rdreq=0.
  - Wait until pend=0 and any full word has been loaded.
  - Then, if 0<cnt<WORD_BYTES and slot free: load partial word. out_keep = (1<<cnt)-1, unused lanes 0, cnt <= 0, return to FILL.
  - If cnt==0: return to FILL with no output.
- flush in the same cycle as an accepted pop: the pop completes, and its byte is included in the flushed word.
- busy = (cnt!=0) OR pend OR out_valid OR flushing.
- empty toggling between pops is legal. No pop is lost or duplicated under any out_ready pattern.
- No combinational path from out_ready to rdreq other than via load.

Test Plan:
- Reset mid-stream:
  - Stimulus: rst pulsed while cnt=1 and out_valid=1.
  - Response: all outputs 0 immediately (async), no rdreq until release, word_count=0.
- Streaming, WORD_BYTES=2:
  - Stimulus: FIFO holds 0x11,0x22,0x33,0x44; out_ready=1.
  - Response: words 0x2211 then 0x4433, keep=2'b11, word_count=2, busy=0 after drain, rdreq never asserted with empty=1.
- Backpressure:
  - Stimulus: 6 bytes 0x01..0x06, out_ready=0 for 10 cycles, then 1.
  - Response: out_data holds 0x0201 stable. rdreq stops once the accumulator is full with 0x0403 and the output slot is occupied. The 0x0403 word is not emitted until out_ready=1. Then 0x0403 and 0x0605 follow with no loss.
- Partial flush:
  - Stimulus: 3 bytes 0xA1,0xB2,0xC3, then flush.
  - Response: 0xB2A1 keep=11, then 0x00C3 keep=01, word_count=2.
- Flush with pop in flight:
  - Stimulus: flush asserted in the same cycle as the accepted pop of 0x5A, with cnt=0.
  - Response: one word 0x005A keep=01. Flush with cnt=0 and no pend produces no word.
- Wrap:
  - Stimulus: CNT_W=4, 17 words.
  - Response: word_count=1.
